ext_bus_periph: RTL

EXT_BUS_PERIPH -- requirements
Module: ext_bus_periph

---
 rtl/ext_bus_pkg.sv | 22 ++
 rtl/irq_edge_sync.sv | 46 ++++
 rtl/ext_bus_periph.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external-bus peripheral.
//   bus_state_e : transaction FSM states (IDLE, WAIT, ACK, DONE)
//   REG_*       : word indices of the fixed registers in the register map
//   WAIT_CNT_W  : width of the wait-state counter (holds 0..15)
package ext_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } bus_state_e;

    localparam int REG_LED      = 0;
    localparam int REG_IRQ_STAT = 1;
    localparam int REG_IRQ_MASK = 2;
    localparam int REG_IRQ_RAW  = 3;
    localparam int REG_SCRATCH0 = 4;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for asynchronous event inputs.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   async_in in   NUM_IRQ raw asynchronous event lines
//   sync_out out  NUM_IRQ synchronised levels
//   rise_out out  NUM_IRQ one-cycle pulses on a synchronised 0->1 transition
module irq_edge_sync
    import ext_bus_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] async_in,
    output logic [NUM_IRQ-1:0] sync_out,
    output logic [NUM_IRQ-1:0] rise_out
);

    logic [NUM_IRQ-1:0] meta_q, meta_d;
    logic [NUM_IRQ-1:0] sync_q, sync_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        // prev holds the synchronised level from the previous cycle for edge detection
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise_out = sync_q & ~prev_q;

endmodule

// File: rtl/ext_bus_periph.sv
// Wait-stated register slave on a simple enable/acknowledge bus, with an LED
// register, edge-triggered interrupt status/mask and scratch registers.
// Ports:
//   clk_clk, reset_reset_n    clock, asynchronous active-low reset
//   bus_enable, rw            transaction request (held to acknowledge), 1 = read
//   address, byte_enable      byte address and per-byte write strobes
//   write_data / read_data    write payload / registered read payload (0 outside ACK)
//   acknowledge               one-cycle completion pulse
//   irq                       registered OR of enabled interrupt status bits
//   irq_src                   asynchronous interrupt event inputs
//   led_out                   LED register drive
module ext_bus_periph
    import ext_bus_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 11,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 2,
    parameter int NUM_IRQ     = 4,
    parameter int LED_W       = 10
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  bus_enable,
    input  logic                  rw,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byte_enable,
    input  logic [DATA_W-1:0]     write_data,
    output logic [DATA_W-1:0]     read_data,
    output logic                  acknowledge,
    output logic                  irq,
    input  logic [NUM_IRQ-1:0]    irq_src,
    output logic [LED_W-1:0]      led_out
);

    localparam int BE_W    = DATA_W / 8;
    localparam int BSH     = $clog2(BE_W);
    localparam int IDX_W   = ADDR_W - BSH;
    localparam int NUM_SCR = NUM_REGS - REG_SCRATCH0;

    // Expand byte strobes into a bit mask covering the whole data word.
    function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) m[b*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    bus_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    irq_q, irq_d;
    logic [LED_W-1:0]        led_q, led_d;
    logic [NUM_IRQ-1:0]      stat_q, stat_d;
    logic [NUM_IRQ-1:0]      mask_q, mask_d;
    logic [DATA_W-1:0]       scr_q [NUM_SCR];
    logic [DATA_W-1:0]       scr_d [NUM_SCR];

    logic                    accept;
    logic [NUM_IRQ-1:0]      irq_raw;
    logic [NUM_IRQ-1:0]      irq_rise;
    logic [IDX_W-1:0]        word_idx;
    logic                    addr_lsb_unused;
    int                      widx;
    logic [DATA_W-1:0]       be_mask;
    logic [DATA_W-1:0]       rd_cur;
    logic [DATA_W-1:0]       wr_word;
    logic                    do_wr;

    irq_edge_sync #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_sync (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .async_in (irq_src),
        .sync_out (irq_raw),
        .rise_out (irq_rise)
    );

    // Byte-offset bits inside a word carry no information for word-wide registers.
    assign word_idx        = address[ADDR_W-1:BSH];
    assign addr_lsb_unused = ^address[BSH-1:0];
    assign widx            = int'(word_idx);

    // Transaction FSM. accept marks the WAIT->ACK edge, at which the access is
    // performed so that register updates and read data line up with acknowledge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus_enable) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES);
                end
            end
            ST_WAIT: begin
                if (!bus_enable) begin
                    // master withdrew the request: abort silently
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // wait for the master to drop its request before re-arming
                if (!bus_enable) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Current value of the addressed register; indices with no register read 0.
    always_comb begin
        rd_cur = '0;
        if (widx == REG_LED) begin
            rd_cur[LED_W-1:0] = led_q;
        end else if (widx == REG_IRQ_STAT) begin
            rd_cur[NUM_IRQ-1:0] = stat_q;
        end else if (widx == REG_IRQ_MASK) begin
            rd_cur[NUM_IRQ-1:0] = mask_q;
        end else if (widx == REG_IRQ_RAW) begin
            rd_cur[NUM_IRQ-1:0] = irq_raw;
        end else begin
            for (int i = 0; i < NUM_SCR; i++) begin
                if (widx == REG_SCRATCH0 + i) rd_cur = scr_q[i];
            end
        end
    end

    // Register write path and interrupt status update.
    always_comb begin
        be_mask = be_to_mask(byte_enable);
        wr_word = (rd_cur & ~be_mask) | (write_data & be_mask);
        do_wr   = accept && !rw;
        led_d   = led_q;
        mask_d  = mask_q;
        scr_d   = scr_q;
        stat_d  = stat_q;
        if (do_wr) begin
            if (widx == REG_LED) begin
                led_d = wr_word[LED_W-1:0];
            end else if (widx == REG_IRQ_STAT) begin
                stat_d = stat_q & ~(write_data[NUM_IRQ-1:0] & be_mask[NUM_IRQ-1:0]);
            end else if (widx == REG_IRQ_MASK) begin
                mask_d = wr_word[NUM_IRQ-1:0];
            end else begin
                for (int i = 0; i < NUM_SCR; i++) begin
                    if (widx == REG_SCRATCH0 + i) scr_d[i] = wr_word;
                end
            end
        end
        // new edges are ORed in after the clear so a coincident set wins
        stat_d  = stat_d | irq_rise;
        ack_d   = accept;
        rdata_d = (accept && rw) ? rd_cur : '0;
        irq_d   = |(stat_q & mask_q);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            led_q   <= '0;
            stat_q  <= '0;
            mask_q  <= '0;
            for (int i = 0; i < NUM_SCR; i++) scr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            led_q   <= led_d;
            stat_q  <= stat_d;
            mask_q  <= mask_d;
            for (int i = 0; i < NUM_SCR; i++) scr_q[i] <= scr_d[i];
        end
    end

    assign read_data   = rdata_q;
    assign acknowledge = ack_q;
    assign irq         = irq_q;
    assign led_out     = led_q;

endmodule
